// File: rtl/uart_wishbone_bridge_if.sv
// Purpose: bundles the UART rx/tx byte streams, the Wishbone classic master bus and busy status.
// Latency: none, wires only.
// Backpressure: rx uses valid/ready, tx uses valid/ready, Wishbone uses ack/err termination.
interface uart_wishbone_bridge_if #(
    parameter int ADDR_WIDTH = 30
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [ADDR_WIDTH-1:0] wb_adr;
    logic [31:0]           wb_dat_w;
    logic [31:0]           wb_dat_r;
    logic [3:0]            wb_sel;
    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_we;
    logic                  wb_ack;
    logic                  wb_err;
    logic                  busy;

    // Bridge side.
    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
        input  wb_dat_r, wb_ack, wb_err,
        output busy
    );

    // Environment side: UART PHY plus the interconnect.
    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
        output wb_dat_r, wb_ack, wb_err,
        input  busy
    );
endinterface

// File: rtl/uart_wishbone_bridge.sv
// Purpose: decodes CMD/LEN/ADDR[/DATA] byte frames into Wishbone classic word reads/writes, replies to reads MSB first.
// Latency: bus cycle starts the clk after the last byte of a word; a 0-wait ack ends it after 1 clk.
// Backpressure: rx_ready drops during bus and reply phases; waits indefinitely on ack/err and tx_ready.
module uart_wishbone_bridge #(
    parameter int ADDR_WIDTH     = 30,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_WIDTH  = 20
) (
    input logic                    clk,
    input logic                    rst,
    uart_wishbone_bridge_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN    = 3'd1,
        ADDR   = 3'd2,
        WDATA  = 3'd3,
        WB_WR  = 3'd4,
        WB_RD  = 3'd5,
        TXBYTE = 3'd6
    } state_t;

    localparam logic [7:0]               CMD_WR   = 8'h01;
    localparam logic [7:0]               CMD_RD   = 8'h02;
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state_q;
    logic                    cmd_wr_q;    // frame is a write
    logic [7:0]              cnt_q;       // words still to transfer
    logic [1:0]              idx_q;       // byte index within address / data word / reply word
    logic [ADDR_WIDTH-1:0]   adr_q;       // address bytes shift straight in; bus is idle then
    logic [31:0]             dat_w_q;
    logic [23:0]             rd_q;        // reply bytes not yet presented on tx
    logic [7:0]              tx_data_q;
    logic                    rx_ready_q;
    logic                    tx_valid_q;
    logic                    cyc_q;
    logic                    we_q;
    logic [3:0]              sel_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_q;

    logic                    rx_fire;
    logic                    tx_fire;
    logic                    bus_done;
    logic                    rx_phase;
    logic [ADDR_WIDTH-1:0]   adr_shift_d;
    logic [ADDR_WIDTH-1:0]   adr_inc_d;
    logic [31:0]             dat_shift_d;
    logic [31:0]             rd_word_d;
    logic [7:0]              cnt_dec_d;

    assign rx_fire     = bus.rx_valid & rx_ready_q;
    assign tx_fire     = tx_valid_q & bus.tx_ready;
    // err wins over a simultaneous ack.
    assign bus_done    = cyc_q & (bus.wb_ack | bus.wb_err);
    assign rx_phase    = (state_q == LEN) || (state_q == ADDR) || (state_q == WDATA);
    assign adr_shift_d = ADDR_WIDTH'({adr_q, bus.rx_data});
    assign adr_inc_d   = adr_q + ADDR_WIDTH'(1);
    assign dat_shift_d = {dat_w_q[23:0], bus.rx_data};
    assign rd_word_d   = bus.wb_err ? 32'h0000_0000 : bus.wb_dat_r;
    assign cnt_dec_d   = cnt_q - 8'd1;

    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.wb_adr   = adr_q;
    assign bus.wb_dat_w = dat_w_q;
    assign bus.wb_sel   = sel_q;
    assign bus.wb_cyc   = cyc_q;
    assign bus.wb_stb   = cyc_q;
    assign bus.wb_we    = we_q;
    assign bus.busy     = (state_q != IDLE);

    // Frame decoder, bus master and reply serialiser; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_wr_q   <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            adr_q      <= '0;
            dat_w_q    <= '0;
            rd_q       <= '0;
            tx_data_q  <= '0;
            rx_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            tmo_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_fire && (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD)) begin
                        cmd_wr_q <= (bus.rx_data == CMD_WR);
                        state_q  <= LEN;
                    end
                end
                LEN: begin
                    if (rx_fire) begin
                        cnt_q   <= bus.rx_data;
                        idx_q   <= '0;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        adr_q <= adr_shift_d;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            if (cnt_q == 8'd0) begin
                                state_q <= IDLE;
                            end else if (cmd_wr_q) begin
                                state_q <= WDATA;
                            end else begin
                                state_q    <= WB_RD;
                                rx_ready_q <= 1'b0;
                                cyc_q      <= 1'b1;
                                we_q       <= 1'b0;
                                sel_q      <= 4'hF;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (rx_fire) begin
                        dat_w_q <= dat_shift_d;
                        idx_q   <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q    <= WB_WR;
                            rx_ready_q <= 1'b0;
                            cyc_q      <= 1'b1;
                            we_q       <= 1'b1;
                            sel_q      <= 4'hF;
                        end
                    end
                end
                WB_WR: begin
                    if (bus_done) begin
                        cyc_q      <= 1'b0;
                        we_q       <= 1'b0;
                        sel_q      <= '0;
                        adr_q      <= adr_inc_d;
                        cnt_q      <= cnt_dec_d;
                        idx_q      <= '0;
                        rx_ready_q <= 1'b1;
                        state_q    <= (cnt_q == 8'd1) ? IDLE : WDATA;
                    end
                end
                WB_RD: begin
                    if (bus_done) begin
                        cyc_q      <= 1'b0;
                        sel_q      <= '0;
                        adr_q      <= adr_inc_d;
                        cnt_q      <= cnt_dec_d;
                        idx_q      <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= rd_word_d[31:24];
                        rd_q       <= rd_word_d[23:0];
                        state_q    <= TXBYTE;
                    end
                end
                TXBYTE: begin
                    if (tx_fire) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            if (cnt_q == 8'd0) begin
                                state_q    <= IDLE;
                                rx_ready_q <= 1'b1;
                            end else begin
                                state_q <= WB_RD;
                                cyc_q   <= 1'b1;
                                sel_q   <= 4'hF;
                            end
                        end else begin
                            tx_data_q <= rd_q[23:16];
                            rd_q      <= {rd_q[15:0], 8'h00};
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Inter-byte timeout: only while waiting for frame bytes; overrides the state above.
            if (rx_phase) begin
                if (rx_fire) begin
                    tmo_q <= '0;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    tmo_q <= tmo_q + TIMEOUT_WIDTH'(1);
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_wishbone_bridge.sv
// Purpose: directed plus randomized frames against a frame-level reference model of the bridge.
// Latency: n/a.
// Backpressure: random or fixed tx_ready stalls and random Wishbone wait states.
module tb_uart_wishbone_bridge;
    localparam int AW  = 30;
    localparam int TMO = 64;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
    } bus_op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_wishbone_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    uart_wishbone_bridge #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_WIDTH  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int vecs       = 0;
    int miscmp     = 0;
    int proto_errs = 0;
    int stab_errs  = 0;

    bus_op_t     bus_log[$];
    bus_op_t     exp_bus[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] wr_words[$];
    logic [31:0] mem     [logic [AW-1:0]];
    logic [31:0] ref_mem [logic [AW-1:0]];

    bit         slv_hold   = 1'b0;
    bit         err_mode   = 1'b0;
    bit         tx_bp_rand = 1'b1;
    int         slv_wait   = 0;
    int         tx_bp      = 0;
    int         tx_wait    = 0;
    bit         prev_v     = 1'b0;
    bit         prev_fire  = 1'b0;
    logic [7:0] prev_d     = 8'h00;
    bus_op_t    mon_op;

    // Background contents of the SoC memory for words never written.
    function automatic logic [31:0] seed_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wishbone slave plus bus protocol watch, all on the falling edge.
    always @(negedge clk) begin
        bus.wb_ack   = 1'b0;
        bus.wb_err   = 1'b0;
        bus.wb_dat_r = $urandom;
        if (!rst) begin
            if (bus.wb_cyc !== bus.wb_stb) proto_errs++;
            if (bus.wb_cyc && bus.wb_sel !== 4'hF) proto_errs++;
            if ((bus.wb_cyc || bus.tx_valid) && (bus.rx_ready || !bus.busy)) proto_errs++;
            if (bus.wb_cyc && !slv_hold) begin
                if (slv_wait > 0) begin
                    slv_wait--;
                end else begin
                    mon_op.we  = bus.wb_we;
                    mon_op.adr = bus.wb_adr;
                    mon_op.dat = bus.wb_we ? bus.wb_dat_w : 32'h0;
                    mon_op.sel = bus.wb_sel;
                    bus_log.push_back(mon_op);
                    bus.wb_ack = 1'b1;
                    if (err_mode) begin
                        bus.wb_err = 1'b1;
                    end else if (!bus.wb_we) begin
                        bus.wb_dat_r = mem.exists(bus.wb_adr) ? mem[bus.wb_adr] : seed_word(bus.wb_adr);
                    end
                    if (bus.wb_we) mem[bus.wb_adr] = bus.wb_dat_w;
                    slv_wait = $urandom_range(0, 2);
                end
            end
        end
    end

    // UART transmitter sink: stalls, records accepted bytes and watches hold stability.
    always @(negedge clk) begin
        bit fire;
        fire = 1'b0;
        if (!rst && prev_v && !prev_fire) begin
            if (!bus.tx_valid || bus.tx_data !== prev_d) stab_errs++;
        end
        if (bus.tx_valid) begin
            if (tx_wait > 0) begin
                bus.tx_ready = 1'b0;
                tx_wait--;
            end else begin
                bus.tx_ready = 1'b1;
                fire = 1'b1;
                tx_log.push_back(bus.tx_data);
                tx_wait = tx_bp_rand ? $urandom_range(0, 3) : tx_bp;
            end
        end else begin
            bus.tx_ready = 1'($urandom_range(0, 1));
        end
        prev_v    = bus.tx_valid;
        prev_d    = bus.tx_data;
        prev_fire = fire;
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("rx_accept", 128'(bus.rx_ready), 128'(1));
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (bus.busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_idle"}, 128'(bus.busy), 128'(0));
    endtask

    // Reference model: a whole frame at once; expected bus words and reply bytes.
    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                             input logic [31:0] addr);
        logic [7:0]    bytes[$];
        logic [AW-1:0] a;
        logic [31:0]   w;
        bus_op_t       op;
        bytes.push_back(cmd);
        bytes.push_back(len);
        bytes.push_back(addr[31:24]);
        bytes.push_back(addr[23:16]);
        bytes.push_back(addr[15:8]);
        bytes.push_back(addr[7:0]);
        a = addr[AW-1:0];
        for (int i = 0; i < int'(len); i++) begin
            if (cmd == 8'h01) begin
                w = (wr_words.size() > 0) ? wr_words.pop_front() : $urandom;
                bytes.push_back(w[31:24]);
                bytes.push_back(w[23:16]);
                bytes.push_back(w[15:8]);
                bytes.push_back(w[7:0]);
                op = '{we: 1'b1, adr: a, dat: w, sel: 4'hF};
                ref_mem[a] = w;
            end else begin
                w = err_mode ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : seed_word(a));
                exp_tx.push_back(w[31:24]);
                exp_tx.push_back(w[23:16]);
                exp_tx.push_back(w[15:8]);
                exp_tx.push_back(w[7:0]);
                op = '{we: 1'b0, adr: a, dat: 32'h0, sel: 4'hF};
            end
            exp_bus.push_back(op);
            a = a + AW'(1);
        end
        foreach (bytes[i]) send_byte(bytes[i]);
        wait_idle(tag);
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_nbus"}, 128'(bus_log.size()), 128'(exp_bus.size()));
        for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++)
            chk({tag, "_bus"}, 128'(bus_log[i]), 128'(exp_bus[i]));
        chk({tag, "_ntx"}, 128'(tx_log.size()), 128'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            chk({tag, "_tx"}, 128'(tx_log[i]), 128'(exp_tx[i]));
        bus_log.delete();
        exp_bus.delete();
        tx_log.delete();
        exp_tx.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (observed timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          t;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", 128'(bus.rx_ready), 128'(1));
        chk("rst_tx_valid", 128'(bus.tx_valid), 128'(0));
        chk("rst_tx_data",  128'(bus.tx_data),  128'(0));
        chk("rst_cyc",      128'(bus.wb_cyc),   128'(0));
        chk("rst_stb",      128'(bus.wb_stb),   128'(0));
        chk("rst_we",       128'(bus.wb_we),    128'(0));
        chk("rst_adr",      128'(bus.wb_adr),   128'(0));
        chk("rst_dat_w",    128'(bus.wb_dat_w), 128'(0));
        chk("rst_sel",      128'(bus.wb_sel),   128'(0));
        chk("rst_busy",     128'(bus.busy),     128'(0));
        rst = 1'b0;

        // Single write.
        wr_words.push_back(32'h0000_000E);
        run_frame("write", 8'h01, 8'h01, 32'h0000_2400);
        check_logs("write");

        // Single read with 3-cycle tx backpressure per byte.
        mem[AW'(32'h0400_0000)]     = 32'h1234_5678;
        ref_mem[AW'(32'h0400_0000)] = 32'h1234_5678;
        tx_bp_rand = 1'b0;
        tx_bp      = 3;
        tx_wait    = 3;
        run_frame("read", 8'h02, 8'h01, 32'h0400_0000);
        check_logs("read");
        chk("read_stable", 128'(stab_errs), 128'(0));
        tx_bp_rand = 1'b1;

        // Burst write, then a zero-length read.
        run_frame("burst", 8'h01, 8'h03, 32'h0000_0010);
        check_logs("burst");
        run_frame("len0", 8'h02, 8'h00, 32'h0000_0010);
        check_logs("len0");

        // Address wrap inside a burst, read back across the wrap.
        run_frame("wrap_wr", 8'h01, 8'h03, 32'hFFFF_FFFF);
        check_logs("wrap_wr");
        run_frame("wrap_rd", 8'h02, 8'h03, 32'h3FFF_FFFF);
        check_logs("wrap_rd");

        // Garbage byte in IDLE.
        send_byte(8'h55);
        @(negedge clk);
        chk("garbage_busy", 128'(bus.busy), 128'(0));
        check_logs("garbage");

        // Partial frame times out after TMO idle cycles.
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (TMO - 1) @(posedge clk);
        #1;
        chk("tmo_before", 128'(bus.busy), 128'(1));
        @(posedge clk);
        #1;
        chk("tmo_after", 128'(bus.busy), 128'(0));
        check_logs("timeout");
        run_frame("post_tmo_wr", 8'h01, 8'h02, 32'h0000_0200);
        check_logs("post_tmo_wr");
        run_frame("post_tmo_rd", 8'h02, 8'h02, 32'h0000_0200);
        check_logs("post_tmo_rd");

        // Randomized frames.
        for (int k = 0; k < 12; k++) begin
            r = $urandom;
            run_frame("rand", 8'($urandom_range(1, 2)), 8'($urandom_range(0, 4)),
                      (k % 3 == 0) ? (r | 32'h3FFF_FFFD) : (r & 32'hF000_000F));
            check_logs("rand");
        end

        // Error termination (ack and err together) reads as zero.
        err_mode = 1'b1;
        run_frame("err", 8'h02, 8'h02, 32'h0000_0010);
        check_logs("err");
        err_mode = 1'b0;

        // Reset in the middle of a bus cycle.
        slv_hold = 1'b1;
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        t = 0;
        @(negedge clk);
        while (!bus.wb_cyc && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mid_cyc_up", 128'(bus.wb_cyc), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_cyc",      128'(bus.wb_cyc),   128'(0));
        chk("mid_rst_stb",      128'(bus.wb_stb),   128'(0));
        chk("mid_rst_tx_valid", 128'(bus.tx_valid), 128'(0));
        chk("mid_rst_rx_ready", 128'(bus.rx_ready), 128'(1));
        chk("mid_rst_busy",     128'(bus.busy),     128'(0));
        @(negedge clk);
        rst      = 1'b0;
        slv_hold = 1'b0;
        repeat (4) @(negedge clk);
        check_logs("mid_rst");
        run_frame("post_rst", 8'h02, 8'h01, 32'h0000_0011);
        check_logs("post_rst");

        chk("protocol", 128'(proto_errs), 128'(0));
        chk("tx_hold",  128'(stab_errs),  128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule

// File: doc/uart_wishbone_bridge.md
Name: uart_wishbone_bridge

Overview:
- Responder end of the UART debug link: takes the byte stream from the UART receiver, decodes write/read commands, and runs Wishbone classic master cycles into the SoC interconnect (DFII CSRs, DRAM port).
- Read responses are returned as a byte stream to the UART transmitter.
- It sits between the uart rx/tx PHY and the SoC bus arbiter.
- It is the unit driven by the simulation host's write/read command sequences.

Parameters:
- ADDR_WIDTH, 30, width of the Wishbone word address; the low ADDR_WIDTH bits of the received 32-bit address are used.
- TIMEOUT_CYCLES, 1000000, idle clk cycles between received bytes before a partial command is dropped.
- TIMEOUT_WIDTH, 20, width of the inter-byte timeout counter.

Ports:
- clk  in  1  system clock (sync domain)
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts the byte; transfer occurs when rx_valid & rx_ready
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts the byte
- wb_adr  out  ADDR_WIDTH  word address
- wb_dat_w  out  32  write data
- wb_dat_r  in  32  read data
- wb_sel  out  4  byte selects, always 4'hF while wb_cyc
- wb_cyc  out  1  bus cycle
- wb_stb  out  1  strobe
- wb_we  out  1  write enable
- wb_ack  in  1  acknowledge
- wb_err  in  1  error termination
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values (sync rst): state=IDLE, rx_ready=1, tx_valid=0, tx_data=0, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_w=0, wb_sel=0, timeout counter=0.
- Frame format: CMD, LEN, A3, A2, A1, A0 (big-endian word address). For CMD 0x01, this is followed by LEN×4 data bytes, MSB first. For CMD 0x02, the bridge replies with LEN×4 bytes, MSB first.
- The address increments by 1 after each word, wrapping modulo 2^ADDR_WIDTH.
- States: IDLE, LEN, ADDR, WDATA, WB_WR, WB_RD, TXBYTE.
- IDLE:
  - Byte 0x01 or 0x02 latches cmd and goes to LEN.
  - Any other byte is consumed and the bridge stays in IDLE.
- LEN:
  - Latches the word count.
  - LEN=0 is legal: the frame ends after the address bytes and no bus cycle or reply is produced.
- ADDR:
  - Collects 4 bytes.
  - After the 4th byte, CMD=0x01 goes to WDATA and CMD=0x02 goes to WB_RD.
- WDATA:
  - Collects 4 bytes into a shift register, then goes to WB_WR.
- WB_WR:
  - rx_ready=0.
  - Asserts cyc, stb and we with wb_dat_w set to the assembled word, sel=F.
  - On ack|err: deassert the bus in the next cycle, increment the address, decrement the count.
  - If count≠0, go to WDATA; otherwise go to IDLE.
- WB_RD:
  - rx_ready=0.
  - Asserts cyc and stb with we=0.
  - On ack, captures wb_dat_r; on err, captures 0x00000000.
  - Then goes to TXBYTE.
- TXBYTE:
  - Presents 4 bytes MSB first, each held stable with tx_valid=1 until tx_ready is sampled high.
  - After the 4th byte: if count≠0, go to WB_RD; otherwise go to IDLE.
  - rx_ready=0 throughout.
- Bus cycles: exactly one cycle per word and no pipelining; cyc and stb always rise and fall together. With an ack in the first cycle, a word's bus cycle lasts 1 clk.
- If ack and err arrive together, the cycle is treated as err.
- rx_ready is high only in IDLE, LEN, ADDR and WDATA.
- Inter-byte timeout:
  - The counter runs only in LEN, ADDR and WDATA, and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES−1, the state returns to IDLE and the partial frame is discarded. Writes already completed stay committed.
- The bridge never times out on Wishbone or on tx_ready; it waits indefinitely.
- rst asserted mid-cycle drops cyc and stb in the next cycle and abandons any pending tx byte; no reply is generated.

Test Plan:
- Write: send 01 01 00 00 24 00 00 00 00 0E → one bus write with adr=0x2400, dat_w=0x0000000E, sel=F, we=1; no tx bytes are produced; busy returns to 0.
- Read: send 02 01 04 00 00 00 with the slave returning 0x12345678 → adr=0x4000000, we=0; tx emits 12, 34, 56, 78 in order. Apply tx_ready backpressure of 3 cycles per byte; the data must stay stable while it waits.
- Burst: send 01 03 00 00 00 10 followed by 12 data bytes → writes at addresses 0x10, 0x11 and 0x12 in order. Then a LEN=0 read → no bus activity and no tx output.
- Garbage and timeout:
  - Byte 0x55 in IDLE → ignored.
  - Send 01 01 00 then stall TIMEOUT_CYCLES (bench sets it to 64) → state returns to IDLE.
  - A following valid frame then executes correctly.
- err and reset:
  - Read with wb_err=1 → tx emits 00 00 00 00.
  - Assert rst while wb_cyc=1 → cyc=0 in the next cycle, tx_valid=0, and the bridge is IDLE with rx_ready=1.
